beep_sequencer: RTL and testbench



---
 rtl/beep_pkg.sv | 88 ++++++++
 rtl/beep_tune_rom.sv | 33 +++
 rtl/beep_sequencer.sv | 169 ++++++++++++++++
 tb/tb_beep_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/beep_pkg.sv
// Shared types, state encoding and tune tables for the beep sequencer.
// Table entries are packed {half, dur}; dur == 0 ends a tune, half == 0 is a rest.
package beep_pkg;

    localparam int PKG_HALF_W  = 20;
    localparam int PKG_DUR_W   = 8;
    localparam int PKG_ENTRY_W = PKG_HALF_W + PKG_DUR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        PLAY  = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic [PKG_HALF_W-1:0] half;
        logic [PKG_DUR_W-1:0]  dur;
    } note_t;

    function automatic note_t note_entry(input int half, input int dur);
        note_t n;
        n.half = PKG_HALF_W'(half);
        n.dur  = PKG_DUR_W'(dur);
        return n;
    endfunction

    // Half-periods assume a 100 MHz clk; durations are 10 ms ticks.
    function automatic note_t game_tune(input int tune, input int idx);
        note_t n;
        n = note_entry(0, 0);
        case (tune)
            1: begin
                case (idx)
                    0: n = note_entry(95556, 10);
                    1: n = note_entry(75843, 10);
                    2: n = note_entry(63776, 10);
                    3: n = note_entry(47778, 30);
                    default: ;
                endcase
            end
            3: begin
                case (idx)
                    0: n = note_entry(127551, 20);
                    1: n = note_entry(151686, 20);
                    2: n = note_entry(0, 10);
                    3: n = note_entry(191109, 40);
                    default: ;
                endcase
            end
            default: ;
        endcase
        return n;
    endfunction

    // Short table sized for simulation with a tiny TICK_CYCLES.
    function automatic note_t sim_tune(input int tune, input int idx);
        note_t n;
        n = note_entry(0, 0);
        case (tune)
            0: if (idx == 0) n = note_entry(4, 1);
            1: begin
                case (idx)
                    0: n = note_entry(3, 2);
                    1: n = note_entry(0, 1);
                    default: ;
                endcase
            end
            2: if (idx == 0) n = note_entry(5, 1);
            3: begin
                case (idx)
                    0: n = note_entry(2, 1);
                    1: n = note_entry(3, 1);
                    2: n = note_entry(1, 1);
                    3: n = note_entry(2, 1);
                    4: n = note_entry(3, 1);
                    5: n = note_entry(1, 1);
                    6: n = note_entry(2, 1);
                    7: n = note_entry(4, 1);
                    default: ;
                endcase
            end
            default: ;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/beep_tune_rom.sv
// Registered tune lookup: (tune, idx) -> {half, dur} one clock later.
module beep_tune_rom
    import beep_pkg::*;
#(
    parameter int MODE_W  = 2,
    parameter int NI_W    = 3,
    parameter int HALF_W  = 20,
    parameter int DUR_W   = 8,
    parameter int SIM_ROM = 0
) (
    input  logic                     clk,
    input  logic [MODE_W-1:0]        tune,
    input  logic [NI_W-1:0]          idx,
    output logic [HALF_W+DUR_W-1:0]  entry_q
);

    note_t                    pkg_note;
    logic [HALF_W+DUR_W-1:0]  entry_d;

    always_comb begin
        if (SIM_ROM != 0) begin
            pkg_note = sim_tune(int'(tune), int'(idx));
        end else begin
            pkg_note = game_tune(int'(tune), int'(idx));
        end
        entry_d = {HALF_W'(pkg_note.half), DUR_W'(pkg_note.dur)};
    end

    always_ff @(posedge clk) begin
        entry_q <= entry_d;
    end

endmodule

// File: rtl/beep_sequencer.sv
// Plays a multi-note tune from the tune ROM whenever the game mode changes into
// a mode selected by PLAY_MASK; drives a registered square wave to the buzzer.
module beep_sequencer
    import beep_pkg::*;
#(
    parameter int                        MODE_W      = 2,
    parameter int                        TUNE_LEN    = 8,
    parameter int                        HALF_W      = 20,
    parameter int                        DUR_W       = 8,
    parameter int                        TICK_CYCLES = 1000000,
    parameter logic [(2**MODE_W)-1:0]    PLAY_MASK   = 4'b1010,
    parameter int                        SIM_ROM     = 0,
    localparam int                       NI_W        = (TUNE_LEN > 1) ? $clog2(TUNE_LEN) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [MODE_W-1:0] gamemode,
    input  logic              mute,
    output logic              beep,
    output logic              busy,
    output logic              done,
    output logic [NI_W-1:0]   note_idx
);

    localparam int             TW       = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TW-1:0]  TICK_MAX = TW'(TICK_CYCLES - 1);
    localparam logic [NI_W-1:0] LAST_IDX = NI_W'(TUNE_LEN - 1);

    state_e              state_q, state_d;
    logic [MODE_W-1:0]   prev_mode_q;
    logic [MODE_W-1:0]   tune_q, tune_d;
    logic [NI_W-1:0]     note_idx_q, note_idx_d;
    logic [TW-1:0]       tick_q, tick_d;
    logic [DUR_W-1:0]    dur_q, dur_d;
    logic [HALF_W-1:0]   half_q, half_d;
    logic [HALF_W-1:0]   half_cnt_q, half_cnt_d;
    logic                tog_q, tog_d;
    logic                beep_q, beep_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [HALF_W+DUR_W-1:0] rom_entry;
    logic [HALF_W-1:0]       rom_half;
    logic [DUR_W-1:0]        rom_dur;
    logic                    mode_change, trigger, abort, note_end;

    assign rom_half = rom_entry[DUR_W +: HALF_W];
    assign rom_dur  = rom_entry[DUR_W-1:0];

    assign mode_change = (gamemode != prev_mode_q);
    assign trigger     = mode_change &&  PLAY_MASK[gamemode];
    assign abort       = mode_change && !PLAY_MASK[gamemode];
    assign note_end    = (tick_q == '0) && (dur_q == DUR_W'(1));

    // ROM is addressed with next-state values so its output is valid during FETCH.
    beep_tune_rom #(
        .MODE_W  (MODE_W),
        .NI_W    (NI_W),
        .HALF_W  (HALF_W),
        .DUR_W   (DUR_W),
        .SIM_ROM (SIM_ROM)
    ) u_rom (
        .clk     (clk),
        .tune    (tune_d),
        .idx     (note_idx_d),
        .entry_q (rom_entry)
    );

    always_comb begin
        state_d    = state_q;
        tune_d     = tune_q;
        note_idx_d = note_idx_q;
        tick_d     = tick_q;
        dur_d      = dur_q;
        half_d     = half_q;
        half_cnt_d = half_cnt_q;
        tog_d      = tog_q;

        case (state_q)
            IDLE: ;
            FETCH: begin
                if (rom_dur == '0) begin
                    state_d = DONE;
                end else begin
                    state_d    = PLAY;
                    half_d     = rom_half;
                    half_cnt_d = rom_half - HALF_W'(1);
                    dur_d      = rom_dur;
                    tick_d     = TICK_MAX;
                    tog_d      = 1'b0;
                end
            end
            PLAY: begin
                if (tick_q == '0) begin
                    tick_d = TICK_MAX;
                    dur_d  = dur_q - DUR_W'(1);
                end else begin
                    tick_d = tick_q - TW'(1);
                end
                if (half_q != '0) begin
                    if (half_cnt_q == '0) begin
                        half_cnt_d = half_q - HALF_W'(1);
                        tog_d      = ~tog_q;
                    end else begin
                        half_cnt_d = half_cnt_q - HALF_W'(1);
                    end
                end
                if (note_end) begin
                    if (note_idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        state_d    = FETCH;
                        note_idx_d = note_idx_q + NI_W'(1);
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A new mode overrides whatever the tune was doing this cycle.
        if (trigger) begin
            state_d    = FETCH;
            tune_d     = gamemode;
            note_idx_d = '0;
        end else if (abort) begin
            state_d = IDLE;
        end

        busy_d = (state_d == FETCH) || (state_d == PLAY);
        done_d = (state_d == DONE);
        beep_d = (state_d == PLAY) && tog_d && !mute;
    end

    always_ff @(posedge clk) begin
        prev_mode_q <= gamemode;
        if (rst) begin
            state_q    <= IDLE;
            tune_q     <= '0;
            note_idx_q <= '0;
            tick_q     <= '0;
            dur_q      <= '0;
            half_q     <= '0;
            half_cnt_q <= '0;
            tog_q      <= 1'b0;
            beep_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tune_q     <= tune_d;
            note_idx_q <= note_idx_d;
            tick_q     <= tick_d;
            dur_q      <= dur_d;
            half_q     <= half_d;
            half_cnt_q <= half_cnt_d;
            tog_q      <= tog_d;
            beep_q     <= beep_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign beep     = beep_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign note_idx = note_idx_q;

endmodule

// File: tb/tb_beep_sequencer.sv
// Directed bench for beep_sequencer using the simulation tune table.
// Expected outputs are queued with the cycle they are due and checked as the DUT reaches it.
module tb_beep_sequencer;

    localparam int TICK = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       mute;
    logic [1:0] gamemode;
    logic       beep, busy, done;
    logic [2:0] note_idx;

    int cyc      = 0;
    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    typedef struct {
        int         at;
        int         field;
        logic [7:0] val;
        string      tag;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    beep_sequencer #(
        .SIM_ROM     (1),
        .TICK_CYCLES (TICK)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .gamemode (gamemode),
        .mute     (mute),
        .beep     (beep),
        .busy     (busy),
        .done     (done),
        .note_idx (note_idx)
    );

    function automatic logic [7:0] observe(input int field);
        case (field)
            0:       return {7'b0, beep};
            1:       return {7'b0, busy};
            2:       return {7'b0, done};
            default: return {5'b0, note_idx};
        endcase
    endfunction

    task automatic expect_at(input int at, input int field, input int val, input string tag);
        exp_t e;
        e.at    = at;
        e.field = field;
        e.val   = 8'(val);
        e.tag   = tag;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == cyc) begin
                n_checks++;
                assert (observe(sb[i].field) === sb[i].val) begin
                    n_pass++;
                end else begin
                    n_fail++;
                    $error("FAIL %s cyc=%0d observed=%0h expected=%0h",
                           sb[i].tag, cyc, observe(sb[i].field), sb[i].val);
                end
                sb.delete(i);
            end
        end
    endtask

    // tune1 = {half 3, dur 2}, {rest, dur 1}, {end}; trigger driven at cycle t.
    task automatic expect_tune1(input int t, input int mute_until, input int last_k, input string lbl);
        for (int k = 1; k <= last_k; k++) begin
            int  c;
            int  b;
            c = t + k;
            b = 0;
            if (k >= 2 && k <= 21) begin
                b = (((k - 2) / 3) % 2 == 1 && c >= mute_until) ? 1 : 0;
            end
            expect_at(c, 0, b, {lbl, "_beep"});
            expect_at(c, 1, (k <= 33) ? 1 : 0, {lbl, "_busy"});
            expect_at(c, 2, (k == 34) ? 1 : 0, {lbl, "_done"});
            if (k == 1 || k == 21) expect_at(c, 3, 0, {lbl, "_idx"});
            if (k == 22 || k == 32) expect_at(c, 3, 1, {lbl, "_idx"});
            if (k == 33) expect_at(c, 3, 2, {lbl, "_idx"});
        end
    endtask

    // tune3: eight one-tick notes, no end marker; s = cycle of the first FETCH.
    task automatic expect_tune3(input int s, input string lbl);
        int halves[8] = '{2, 3, 1, 2, 3, 1, 2, 4};
        for (int n = 0; n < 8; n++) begin
            int base;
            base = s + 11 * n;
            expect_at(base, 3, n, {lbl, "_idx"});
            expect_at(base + TICK, 3, n, {lbl, "_idx"});
            expect_at(base, 1, 1, {lbl, "_busy"});
            expect_at(base, 2, 0, {lbl, "_done"});
            expect_at(base, 0, 0, {lbl, "_beep"});
            for (int j = 0; j < TICK; j++) begin
                expect_at(base + 1 + j, 0, ((j / halves[n]) % 2 == 1) ? 1 : 0, {lbl, "_beep"});
            end
        end
        expect_at(s + 88, 2, 1, {lbl, "_done"});
        expect_at(s + 88, 1, 0, {lbl, "_busy"});
        expect_at(s + 88, 0, 0, {lbl, "_beep"});
        expect_at(s + 88, 3, 7, {lbl, "_idx"});
        expect_at(s + 89, 2, 0, {lbl, "_done"});
        expect_at(s + 89, 1, 0, {lbl, "_busy"});
    endtask

    task automatic expect_quiet(input int from, input int to, input bit chk_idx, input string lbl);
        for (int c = from; c <= to; c++) begin
            expect_at(c, 0, 0, {lbl, "_beep"});
            expect_at(c, 1, 0, {lbl, "_busy"});
            expect_at(c, 2, 0, {lbl, "_done"});
            if (chk_idx) expect_at(c, 3, 0, {lbl, "_idx"});
        end
    endtask

    task automatic settle_mode0();
        gamemode = 2'b00;
        tick();
        tick();
    endtask

    initial begin
        int t;
        rst      = 1'b1;
        mute     = 1'b0;
        gamemode = 2'b00;

        // reset values
        expect_quiet(1, 7, 1'b1, "reset");
        repeat (3) tick();
        rst = 1'b0;
        repeat (4) tick();

        // plain tune1
        t = cyc;
        gamemode = 2'b01;
        expect_tune1(t, 0, 36, "tune1");
        repeat (40) tick();

        // muted tune1, mute released mid-note
        settle_mode0();
        t = cyc;
        mute = 1'b1;
        gamemode = 2'b01;
        expect_tune1(t, t + 11, 36, "mute");
        for (int k = 0; k < 40; k++) begin
            tick();
            if (cyc == t + 10) mute = 1'b0;
        end

        // abort into unmasked mode during note 0
        settle_mode0();
        t = cyc;
        gamemode = 2'b01;
        expect_tune1(t, 0, 5, "abort");
        expect_quiet(t + 6, t + 40, 1'b0, "abort_after");
        for (int k = 0; k < 42; k++) begin
            tick();
            if (cyc == t + 5) gamemode = 2'b10;
        end

        // restart into tune3 during the tune1 rest, then full-length tune3
        settle_mode0();
        t = cyc;
        gamemode = 2'b01;
        expect_tune1(t, 0, 25, "restart");
        expect_tune3(t + 26, "tune3");
        for (int k = 0; k < 118; k++) begin
            tick();
            if (cyc == t + 25) gamemode = 2'b11;
        end

        // trigger in the same cycle tune1 would naturally end
        settle_mode0();
        t = cyc;
        gamemode = 2'b01;
        expect_tune1(t, 0, 33, "collide");
        expect_tune3(t + 34, "collide3");
        for (int k = 0; k < 126; k++) begin
            tick();
            if (cyc == t + 33) gamemode = 2'b11;
        end

        // synchronous reset mid-PLAY with the triggering mode held
        settle_mode0();
        t = cyc;
        gamemode = 2'b01;
        expect_tune1(t, 0, 6, "rst_mid");
        expect_quiet(t + 7, t + 40, 1'b1, "rst_after");
        for (int k = 0; k < 42; k++) begin
            tick();
            if (cyc == t + 6) rst = 1'b1;
            if (cyc == t + 9) rst = 1'b0;
        end

        if (sb.size() != 0) begin
            n_checks += sb.size();
            n_fail   += sb.size();
            $error("FAIL scoreboard observed=%0d unchecked entries expected=0", sb.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
